// File: rtl/fpadd_pkg.sv
// Shared types and constants for the FP32 adder control sequencer.
// Consumers: fpadd_seq (optional feature macro FPADD_ALIGN_SKIP_EN lives there).
package fpadd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CMP,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_DONE
   } state_e;

   localparam int ALIGN_LIMIT = 25;
   localparam int NORM_MAX    = 24;

   localparam int                EXP_W   = 8;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFE;

endpackage

// File: rtl/fpadd_seq.sv
// Control sequencer driving the FP32 adder datapath strobes from start to done.
// Optional feature: define FPADD_ALIGN_SKIP_EN to flush the smaller mantissa on huge exponent gaps.
module fpadd_seq
   import fpadd_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             b_gt,
   input  logic [EXP_W-1:0] diff,
   input  logic             mant_carry,
   input  logic             mant_msb,
   input  logic             mant_zero,
   input  logic             expo_zero,
   input  logic             expo_max,
   output logic             lda,
   output logic             swap,
   output logic             ldex,
   output logic             ince,
   output logic             dece,
   output logic             shra,
   output logic             flush,
   output logic             addm,
   output logic             shrm,
   output logic             shlm,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic             err
);

   localparam logic [4:0] NORM_LAST = 5'(NORM_MAX - 1);

   state_e           state_q, state_d;
   logic [EXP_W-1:0] align_cnt_q, align_cnt_d;
   logic [4:0]       norm_cnt_q, norm_cnt_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic             align_skip;

`ifdef FPADD_ALIGN_SKIP_EN
   // A flushed cycle leaves the counter at zero, so the next ALIGN cycle exits like one shift.
   assign align_skip = (align_cnt_q >= EXP_W'(ALIGN_LIMIT));
`else
   assign align_skip = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         align_cnt_q <= '0;
         norm_cnt_q  <= '0;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         align_cnt_q <= align_cnt_d;
         norm_cnt_q  <= norm_cnt_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      align_cnt_d = align_cnt_q;
      norm_cnt_d  = norm_cnt_q;
      ovf_d       = ovf_q;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               ovf_d      = 1'b0;
               err_d      = 1'b0;
               norm_cnt_d = '0;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_CMP;
         ST_CMP: begin
            align_cnt_d = diff;
            state_d     = ST_ALIGN;
         end
         ST_ALIGN: begin
            if (align_skip) begin
               align_cnt_d = '0;
            end else if (align_cnt_q == '0) begin
               state_d = ST_ADD;
            end else begin
               align_cnt_d = align_cnt_q - 1'b1;
            end
         end
         ST_ADD: state_d = ST_NORM;
         ST_NORM: begin
            // Carry beats every other exit; zero/denormal results stop shifting immediately.
            if (mant_carry) begin
               if (expo_max) ovf_d = 1'b1;
               state_d = ST_DONE;
            end else if (mant_zero || mant_msb || expo_zero) begin
               state_d = ST_DONE;
            end else if (norm_cnt_q == NORM_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               norm_cnt_d = norm_cnt_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      lda   = 1'b0;
      swap  = 1'b0;
      ldex  = 1'b0;
      ince  = 1'b0;
      dece  = 1'b0;
      shra  = 1'b0;
      flush = 1'b0;
      addm  = 1'b0;
      shrm  = 1'b0;
      shlm  = 1'b0;
      done  = 1'b0;
      busy  = (state_q != ST_IDLE);
      ovf   = ovf_q;
      err   = err_q;
      case (state_q)
         ST_LOAD: lda = 1'b1;
         ST_CMP: begin
            ldex = 1'b1;
            swap = b_gt;
         end
         ST_ALIGN: begin
            flush = align_skip;
            shra  = !align_skip && (align_cnt_q != '0);
         end
         ST_ADD: addm = 1'b1;
         ST_NORM: begin
            if (mant_carry) begin
               shrm = 1'b1;
               ince = 1'b1;
            end else if (!(mant_zero || mant_msb || expo_zero) && (norm_cnt_q != NORM_LAST)) begin
               shlm = 1'b1;
               dece = 1'b1;
            end
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fpadd_seq.sv
// Directed self-checking bench for fpadd_seq; cycle numbers count from the edge that samples start.
module tb_fpadd_seq;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       b_gt;
   logic [7:0] diff;
   logic       mant_carry, mant_msb, mant_zero, expo_zero, expo_max;
   logic       lda, swap, ldex, ince, dece, shra, flush, addm, shrm, shlm;
   logic       busy, done, ovf, err;

   int checks   = 0;
   int failures = 0;

   int done_cycle, n_lda, n_ldex, n_swap, n_swap_ldex, n_shra, n_flush, n_addm;
   int n_ince, n_dece, n_shrm_ince, n_shlm_dece, n_excl, n_busy_gap;
   logic ovf_at_done, err_at_done, ovf_c1, err_c1, busy_after, done_after;

   always #5 clk = ~clk;

   fpadd_seq dut (
      .clk(clk), .reset_n(reset_n), .start(start), .b_gt(b_gt), .diff(diff),
      .mant_carry(mant_carry), .mant_msb(mant_msb), .mant_zero(mant_zero),
      .expo_zero(expo_zero), .expo_max(expo_max),
      .lda(lda), .swap(swap), .ldex(ldex), .ince(ince), .dece(dece),
      .shra(shra), .flush(flush), .addm(addm), .shrm(shrm), .shlm(shlm),
      .busy(busy), .done(done), .ovf(ovf), .err(err)
   );

   // Starts one operation from the current point, models mant_msb rising after msb_after shlm pulses.
   task automatic run_op(input int msb_after, input int extra_start, input int limit);
      int cyc;
      int shl;
      cyc = 0; shl = 0;
      done_cycle = -1; n_lda = 0; n_ldex = 0; n_swap = 0; n_swap_ldex = 0; n_shra = 0;
      n_flush = 0; n_addm = 0; n_ince = 0; n_dece = 0; n_shrm_ince = 0; n_shlm_dece = 0;
      n_excl = 0; n_busy_gap = 0;
      ovf_at_done = 1'bx; err_at_done = 1'bx; ovf_c1 = 1'bx; err_c1 = 1'bx;
      mant_msb = (msb_after == 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (done_cycle < 0 && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin ovf_c1 = ovf; err_c1 = err; end
         if (!busy) n_busy_gap++;
         n_lda += int'(lda);  n_ldex += int'(ldex); n_swap += int'(swap);
         n_shra += int'(shra); n_flush += int'(flush); n_addm += int'(addm);
         n_ince += int'(ince); n_dece += int'(dece);
         if (swap && ldex) n_swap_ldex++;
         if (shrm && ince) n_shrm_ince++;
         if (shlm && dece) n_shlm_dece++;
         if ((int'(ldex) + int'(ince) + int'(dece) > 1) ||
             (int'(shra) + int'(flush) + int'(shrm) + int'(shlm) > 1)) n_excl++;
         if (shlm) shl++;
         if (done) begin done_cycle = cyc; ovf_at_done = ovf; err_at_done = err; end
         @(posedge clk); #1;
         mant_msb = (msb_after >= 0) && (shl >= msb_after);
         start = (cyc + 1 == extra_start);
      end
      start = 1'b0;
      @(negedge clk);
      busy_after = busy;
      done_after = done;
   endtask

   task automatic set_status(input logic bg, input logic [7:0] df, input logic cy, input logic emax);
      b_gt = bg; diff = df; mant_carry = cy; expo_max = emax;
      mant_zero = 1'b0; expo_zero = 1'b0;
   endtask

   task automatic test_reset();
      logic [13:0] outs;
      reset_n = 1'b0; start = 1'b0;
      set_status(1'b1, 8'd5, 1'b0, 1'b0);
      mant_msb = 1'b0;
      repeat (2) @(negedge clk);
      outs = {lda, swap, ldex, ince, dece, shra, flush, addm, shrm, shlm, busy, done, ovf, err};
      checks++;
      if (outs !== 14'd0) begin failures++; $display("[TB] FAIL reset_outputs: got %b expected 0", outs); end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_equal_exp();
      @(negedge clk);
      set_status(1'b0, 8'd0, 1'b0, 1'b0);
      run_op(0, -1, 40);
      checks++; if (done_cycle !== 6) begin failures++; $display("[TB] FAIL eq_done_cycle: got %0d expected 6", done_cycle); end
      checks++; if (n_lda !== 1) begin failures++; $display("[TB] FAIL eq_lda: got %0d expected 1", n_lda); end
      checks++; if (n_ldex !== 1) begin failures++; $display("[TB] FAIL eq_ldex: got %0d expected 1", n_ldex); end
      checks++; if (n_addm !== 1) begin failures++; $display("[TB] FAIL eq_addm: got %0d expected 1", n_addm); end
      checks++; if (n_ince + n_dece !== 0) begin failures++; $display("[TB] FAIL eq_ince_dece: got %0d expected 0", n_ince + n_dece); end
      checks++; if (n_swap !== 0) begin failures++; $display("[TB] FAIL eq_swap: got %0d expected 0", n_swap); end
      checks++; if (n_busy_gap !== 0) begin failures++; $display("[TB] FAIL eq_busy_during: got %0d idle cycles expected 0", n_busy_gap); end
      checks++; if (busy_after !== 1'b0) begin failures++; $display("[TB] FAIL eq_busy_after: got %b expected 0", busy_after); end
   endtask

   task automatic test_align();
      @(negedge clk);
      set_status(1'b1, 8'd3, 1'b0, 1'b0);
      run_op(0, -1, 40);
      checks++; if (n_swap_ldex !== 1) begin failures++; $display("[TB] FAIL al_swap_ldex: got %0d expected 1", n_swap_ldex); end
      checks++; if (n_swap !== 1) begin failures++; $display("[TB] FAIL al_swap_total: got %0d expected 1", n_swap); end
      checks++; if (n_shra !== 3) begin failures++; $display("[TB] FAIL al_shra: got %0d expected 3", n_shra); end
      checks++; if (done_cycle !== 9) begin failures++; $display("[TB] FAIL al_done_cycle: got %0d expected 9", done_cycle); end
   endtask

   task automatic test_carry();
      @(negedge clk);
      set_status(1'b0, 8'd0, 1'b1, 1'b1);
      run_op(0, -1, 40);
      checks++; if (n_shrm_ince !== 1) begin failures++; $display("[TB] FAIL cy_shrm_ince: got %0d expected 1", n_shrm_ince); end
      checks++; if (done_cycle !== 6) begin failures++; $display("[TB] FAIL cy_done_cycle: got %0d expected 6", done_cycle); end
      checks++; if (ovf_at_done !== 1'b1) begin failures++; $display("[TB] FAIL cy_ovf_at_done: got %b expected 1", ovf_at_done); end
      checks++; if (ovf !== 1'b1) begin failures++; $display("[TB] FAIL cy_ovf_sticky: got %b expected 1", ovf); end
      set_status(1'b0, 8'd0, 1'b0, 1'b0);
      run_op(0, -1, 40);
      checks++; if (ovf_c1 !== 1'b0) begin failures++; $display("[TB] FAIL cy_ovf_cleared: got %b expected 0", ovf_c1); end
      checks++; if (ovf_at_done !== 1'b0) begin failures++; $display("[TB] FAIL cy_ovf_next_done: got %b expected 0", ovf_at_done); end
   endtask

   task automatic test_left_norm();
      @(negedge clk);
      set_status(1'b0, 8'd0, 1'b0, 1'b0);
      run_op(5, -1, 60);
      checks++; if (n_shlm_dece !== 5) begin failures++; $display("[TB] FAIL ln_shlm_dece: got %0d expected 5", n_shlm_dece); end
      checks++; if (done_cycle !== 11) begin failures++; $display("[TB] FAIL ln_done_cycle: got %0d expected 11", done_cycle); end
      checks++; if (n_excl !== 0) begin failures++; $display("[TB] FAIL ln_exclusive: got %0d expected 0", n_excl); end
      checks++; if (err_at_done !== 1'b0) begin failures++; $display("[TB] FAIL ln_err: got %b expected 0", err_at_done); end
      run_op(-1, -1, 80);
      checks++; if (n_shlm_dece !== 23) begin failures++; $display("[TB] FAIL ln_bound_shifts: got %0d expected 23", n_shlm_dece); end
      checks++; if (done_cycle !== 29) begin failures++; $display("[TB] FAIL ln_bound_done: got %0d expected 29", done_cycle); end
      checks++; if (err_at_done !== 1'b1) begin failures++; $display("[TB] FAIL ln_bound_err: got %b expected 1", err_at_done); end
      run_op(0, -1, 40);
      checks++; if (err_c1 !== 1'b0) begin failures++; $display("[TB] FAIL ln_err_cleared: got %b expected 0", err_c1); end
   endtask

   task automatic test_large_diff();
      @(negedge clk);
      set_status(1'b0, 8'd40, 1'b0, 1'b0);
      run_op(0, -1, 120);
`ifdef FPADD_ALIGN_SKIP_EN
      checks++; if (n_flush !== 1) begin failures++; $display("[TB] FAIL ld_flush: got %0d expected 1", n_flush); end
      checks++; if (n_shra !== 0) begin failures++; $display("[TB] FAIL ld_shra: got %0d expected 0", n_shra); end
      checks++; if (done_cycle !== 7) begin failures++; $display("[TB] FAIL ld_done_cycle: got %0d expected 7", done_cycle); end
`else
      checks++; if (n_flush !== 0) begin failures++; $display("[TB] FAIL ld_flush: got %0d expected 0", n_flush); end
      checks++; if (n_shra !== 40) begin failures++; $display("[TB] FAIL ld_shra: got %0d expected 40", n_shra); end
      checks++; if (done_cycle !== 46) begin failures++; $display("[TB] FAIL ld_done_cycle: got %0d expected 46", done_cycle); end
`endif
   endtask

   task automatic test_mid_reset();
      logic [13:0] outs;
      @(negedge clk);
      set_status(1'b0, 8'd10, 1'b0, 1'b0);
      mant_msb = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (shra !== 1'b1) begin failures++; $display("[TB] FAIL mr_in_align: got shra=%b expected 1", shra); end
      #1 reset_n = 1'b0;
      #1 outs = {lda, swap, ldex, ince, dece, shra, flush, addm, shrm, shlm, busy, done, ovf, err};
      checks++; if (outs !== 14'd0) begin failures++; $display("[TB] FAIL mr_outputs: got %b expected 0", outs); end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mr_idle: got busy=%b expected 0", busy); end
      diff = 8'd0;
      run_op(0, -1, 40);
      checks++; if (done_cycle !== 6) begin failures++; $display("[TB] FAIL mr_next_done: got %0d expected 6", done_cycle); end
   endtask

   task automatic test_busy_start();
      int extra;
      @(negedge clk);
      set_status(1'b0, 8'd2, 1'b0, 1'b0);
      run_op(0, 3, 40);
      extra = int'(done_after);
      repeat (10) begin
         @(negedge clk);
         extra += int'(done);
      end
      checks++; if (done_cycle !== 8) begin failures++; $display("[TB] FAIL bs_done_cycle: got %0d expected 8", done_cycle); end
      checks++; if (extra !== 0) begin failures++; $display("[TB] FAIL bs_extra_done: got %0d expected 0", extra); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      set_status(1'b1, 8'd1, 1'b0, 1'b0);
      run_op(0, -1, 40);
      checks++; if (done_cycle !== 7) begin failures++; $display("[TB] FAIL bb_first_done: got %0d expected 7", done_cycle); end
      set_status(1'b0, 8'd0, 1'b0, 1'b0);
      run_op(0, -1, 40);
      checks++; if (done_cycle !== 6) begin failures++; $display("[TB] FAIL bb_second_done: got %0d expected 6", done_cycle); end
      checks++; if (n_lda !== 1) begin failures++; $display("[TB] FAIL bb_second_lda: got %0d expected 1", n_lda); end
   endtask

   initial begin
      test_reset();
      test_equal_exp();
      test_align();
      test_carry();
      test_left_norm();
      test_large_diff();
      test_mid_reset();
      test_busy_start();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
